// File: rtl/image_load_pkg.sv
// Shared constants, output FSM encoding and sizing helper for the frame reader.
package image_load_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 10;
    localparam int unsigned DEF_DOUT_WIDTH_LOG = 4;
    localparam int unsigned DEF_AVM_WIDTH_LOG  = 6;
    localparam int unsigned DEF_FIFO_DEPTH_LOG = 4;

    // Pixels per memory word and bytes per memory word for the default geometry.
    localparam int unsigned PPW_LOG = DEF_AVM_WIDTH_LOG - DEF_DOUT_WIDTH_LOG;
    localparam int unsigned PPW     = 1 << PPW_LOG;
    localparam int unsigned BPW     = 1 << (DEF_AVM_WIDTH_LOG - 3);

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_HDR  = 2'd1,
        O_PIX  = 2'd2
    } out_state_t;

    // Number of memory words holding cnt pixels, rounded up.
    function automatic logic [31:0] words_for(input logic [31:0] cnt, input int unsigned ppw_log);
        return (cnt + ((32'd1 << ppw_log) - 32'd1)) >> ppw_log;
    endfunction

endpackage

// File: rtl/image_load_fifo.sv
// Synchronous show-ahead word FIFO: dout always presents the oldest stored word.
module image_load_fifo #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr,
    input  logic [WIDTH-1:0]     din,
    input  logic                 rd,
    output logic [WIDTH-1:0]     dout,
    output logic                 empty,
    output logic [DEPTH_LOG:0]   usedw
);

    logic [WIDTH-1:0]     mem [2**DEPTH_LOG];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic [DEPTH_LOG:0]   count;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign usedw = count;

endmodule

// File: rtl/image_load_avalon_master.sv
// Frame reader: fetches packed pixel words over Avalon-MM and emits one Avalon-ST video packet.
module image_load_avalon_master
    import image_load_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned DOUT_WIDTH_LOG = DEF_DOUT_WIDTH_LOG,
    parameter int unsigned AVM_WIDTH_LOG  = DEF_AVM_WIDTH_LOG,
    parameter int unsigned FIFO_DEPTH_LOG = DEF_FIFO_DEPTH_LOG,
    parameter bit          EMIT_HEADER    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [31:0]                   avm_address,
    output logic                          avm_read,
    input  logic [(2**AVM_WIDTH_LOG)-1:0] avm_readdata,
    input  logic                          avm_waitrequest,
    input  logic                          avm_readdatavalid,
    output logic [DATA_WIDTH-1:0]         dout_data,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          dout_startofpacket,
    output logic                          dout_endofpacket,
    input  logic                          sig_start,
    input  logic [31:0]                   sig_address,
    input  logic [31:0]                   sig_pixel_cnt,
    output logic                          sig_busy,
    output logic                          sig_done,
    output logic [31:0]                   sig_frame_cnt
);

    localparam int unsigned WPPW_LOG = AVM_WIDTH_LOG - DOUT_WIDTH_LOG;
    localparam int unsigned AVM_W    = 1 << AVM_WIDTH_LOG;
    localparam logic [31:0] BPW_B    = 32'(1 << (AVM_WIDTH_LOG - 3));
    localparam logic [FIFO_DEPTH_LOG+1:0] DEPTH_W = (FIFO_DEPTH_LOG+2)'(1 << FIFO_DEPTH_LOG);

    out_state_t state, state_nxt;

    logic [31:0]               addr_q, cnt_q, words_q, issued_q, pix_sent_q, frame_cnt_q;
    logic [WPPW_LOG-1:0]       idx_q;
    logic [FIFO_DEPTH_LOG:0]   outstanding_q;
    logic                      done_q;

    logic [AVM_W-1:0]          fifo_dout;
    logic                      fifo_empty;
    logic [FIFO_DEPTH_LOG:0]   fifo_used;
    logic [FIFO_DEPTH_LOG+1:0] in_flight;
    logic                      start_ok, accept, fire, last_pix, pop;

    assign start_ok  = (state == O_IDLE) && sig_start && (sig_pixel_cnt != '0);
    assign in_flight = {1'b0, outstanding_q} + {1'b0, fifo_used};
    // Requests already accepted plus words buffered must fit in the FIFO; this sum can only
    // shrink during a stall, so avm_read stays asserted until accepted.
    assign avm_read  = (state != O_IDLE) && (issued_q < words_q) && (in_flight < DEPTH_W);
    assign accept    = avm_read && !avm_waitrequest;
    assign fire      = dout_valid && dout_ready;
    assign last_pix  = (state == O_PIX) && (pix_sent_q == cnt_q - 32'd1);
    assign pop       = fire && (state == O_PIX) && ((&idx_q) || last_pix);

    assign avm_address   = addr_q;
    assign sig_busy      = (state != O_IDLE);
    assign sig_done      = done_q;
    assign sig_frame_cnt = frame_cnt_q;

    image_load_fifo #(
        .WIDTH     (AVM_W),
        .DEPTH_LOG (FIFO_DEPTH_LOG)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (avm_readdatavalid),
        .din   (avm_readdata),
        .rd    (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .usedw (fifo_used)
    );

    // Output FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= O_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and stream outputs; pixel beats come straight off the show-ahead FIFO head.
    always_comb begin
        state_nxt          = state;
        dout_valid         = 1'b0;
        dout_data          = '0;
        dout_startofpacket = 1'b0;
        dout_endofpacket   = 1'b0;
        case (state)
            O_IDLE: begin
                if (start_ok) state_nxt = EMIT_HEADER ? O_HDR : O_PIX;
            end
            O_HDR: begin
                dout_valid         = 1'b1;
                dout_startofpacket = 1'b1;
                if (fire) state_nxt = O_PIX;
            end
            O_PIX: begin
                dout_valid         = !fifo_empty;
                dout_data          = fifo_dout[{idx_q, {DOUT_WIDTH_LOG{1'b0}}} +: DATA_WIDTH];
                dout_startofpacket = !EMIT_HEADER && (pix_sent_q == '0);
                dout_endofpacket   = last_pix;
                if (fire && last_pix) state_nxt = O_IDLE;
            end
            default: state_nxt = O_IDLE;
        endcase
    end

    // Frame parameters, read-side request tracking and pixel position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            words_q    <= '0;
            issued_q   <= '0;
            pix_sent_q <= '0;
            idx_q      <= '0;
        end else if (start_ok) begin
            addr_q     <= sig_address;
            cnt_q      <= sig_pixel_cnt;
            words_q    <= words_for(sig_pixel_cnt, WPPW_LOG);
            issued_q   <= '0;
            pix_sent_q <= '0;
            idx_q      <= '0;
        end else begin
            if (accept) begin
                issued_q <= issued_q + 32'd1;
                addr_q   <= addr_q + BPW_B;
            end
            if (fire && state == O_PIX) begin
                pix_sent_q <= pix_sent_q + 32'd1;
                idx_q      <= pop ? '0 : idx_q + 1'b1;
            end
        end
    end

    // Reads accepted but not yet returned; accept and return together leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
        end else begin
            case ({accept, avm_readdatavalid})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Frame completion pulse and wrapping frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            done_q <= fire && last_pix;
            if (fire && last_pix) frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_image_load_avalon_master.sv
// Directed bench for the frame reader with a latency memory model and a beat scoreboard.
module tb_image_load_avalon_master;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [63:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [9:0]  dout_data;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_startofpacket;
    logic        dout_endofpacket;
    logic        sig_start;
    logic [31:0] sig_address;
    logic [31:0] sig_pixel_cnt;
    logic        sig_busy;
    logic        sig_done;
    logic [31:0] sig_frame_cnt;

    image_load_avalon_master #(
        .DATA_WIDTH     (10),
        .DOUT_WIDTH_LOG (4),
        .AVM_WIDTH_LOG  (6),
        .FIFO_DEPTH_LOG (4),
        .EMIT_HEADER    (1'b1)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .avm_address        (avm_address),
        .avm_read           (avm_read),
        .avm_readdata       (avm_readdata),
        .avm_waitrequest    (avm_waitrequest),
        .avm_readdatavalid  (avm_readdatavalid),
        .dout_data          (dout_data),
        .dout_valid         (dout_valid),
        .dout_ready         (dout_ready),
        .dout_startofpacket (dout_startofpacket),
        .dout_endofpacket   (dout_endofpacket),
        .sig_start          (sig_start),
        .sig_address        (sig_address),
        .sig_pixel_cnt      (sig_pixel_cnt),
        .sig_busy           (sig_busy),
        .sig_done           (sig_done),
        .sig_frame_cnt      (sig_frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_q [$];   // {sop, eop, data}
    logic [31:0] pend_a [$];
    int          pend_t [$];

    int          cyc = 0;
    logic [31:0] exp_base = '0;
    int          exp_words = 0;
    int          acc_cnt = 0;
    int          pix_out = 0;
    int          done_seen = 0;
    int          exp_frames = 0;
    int          stall_req = 0;
    bit          in_stall = 1'b0;
    bit          credit_chk = 1'b0;
    logic [31:0] stall_addr = '0;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'h5A3C_96E1, (a * 32'd2654435761) ^ 32'h0F0F_1234};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory slave: stall control, address sequence checks, fixed-latency responses.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend_a.delete();
            pend_t.delete();
            avm_readdatavalid = 1'b0;
            avm_readdata      = '0;
            avm_waitrequest   = 1'b0;
            in_stall          = 1'b0;
        end else begin
            if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = mem_word(pend_a.pop_front());
                void'(pend_t.pop_front());
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata      = '0;
            end
            if (in_stall) begin
                chk("stall_read_held", avm_read, 1);
                chk("stall_addr_held", avm_address, stall_addr);
            end
            if (avm_read && stall_req > 0) begin
                if (!in_stall) stall_addr = avm_address;
                avm_waitrequest = 1'b1;
                in_stall        = 1'b1;
                stall_req--;
            end else begin
                avm_waitrequest = 1'b0;
                in_stall        = 1'b0;
            end
            if (avm_read && !avm_waitrequest) begin
                chk("rd_addr", avm_address, exp_base + 32'(8 * acc_cnt));
                chk("rd_in_range", acc_cnt < exp_words, 1);
                pend_a.push_back(avm_address);
                pend_t.push_back(cyc + LAT);
                acc_cnt++;
            end
            if (credit_chk) chk("credit", (acc_cnt - pix_out / 4) <= 16, 1);
        end
    end

    // Stream monitor: pops the scoreboard on every handshake, counts done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sig_done) begin
                done_seen++;
                chk("done_not_busy", sig_busy, 0);
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
                else chk("beat", {dout_startofpacket, dout_endofpacket, dout_data}, exp_q.pop_front());
                if (!dout_startofpacket) pix_out++;
            end
        end
    end

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame(input logic [31:0] a, input logic [31:0] n);
        logic [63:0] w;
        exp_base  = a;
        exp_words = int'((n + 32'd3) / 32'd4);
        acc_cnt   = 0;
        pix_out   = 0;
        exp_q.push_back({1'b1, 1'b0, 10'd0});
        for (int k = 0; k < int'(n); k++) begin
            w = mem_word(a + 32'(8 * (k / 4)));
            exp_q.push_back({1'b0, (k == int'(n) - 1), w[16 * (k % 4) +: 10]});
        end
        sig_address   = a;
        sig_pixel_cnt = n;
        sig_start     = 1'b1;
        cycle(1);
        sig_start = 1'b0;
        chk("busy_after_start", sig_busy, 1);
        chk("hdr_valid_after_start", dout_valid, 1);
        chk("read_after_start", avm_read, 1);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_seen;
        k  = 0;
        while (done_seen == d0 && k < budget) begin
            cycle(1);
            k++;
        end
        chk("done_timeout", done_seen != d0, 1);
        exp_frames++;
        chk("sb_empty", exp_q.size(), 0);
        chk("frame_cnt", sig_frame_cnt, exp_frames);
        chk("read_count", acc_cnt, exp_words);
        chk("busy_end", sig_busy, 0);
        cycle(4);
        chk("done_once", done_seen, d0 + 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_avm_read"}, avm_read, 0);
        chk({tag, "_avm_address"}, avm_address, 0);
        chk({tag, "_dout_valid"}, dout_valid, 0);
        chk({tag, "_dout_data"}, dout_data, 0);
        chk({tag, "_sop_eop"}, {dout_startofpacket, dout_endofpacket}, 0);
        chk({tag, "_busy_done"}, {sig_busy, sig_done}, 0);
        chk({tag, "_frame_cnt"}, sig_frame_cnt, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        dout_ready    = 1'b1;
        sig_start     = 1'b0;
        sig_address   = '0;
        sig_pixel_cnt = '0;
        cycle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        cycle(2);

        // 1: basic 8-pixel frame
        start_frame(32'h0040_0000, 32'd8);
        wait_done(200);

        // 2: partial last word
        start_frame(32'h0040_0100, 32'd6);
        wait_done(200);

        // 3: five-cycle stall on the first read
        stall_req = 5;
        start_frame(32'h0040_0200, 32'd12);
        wait_done(200);
        chk("stall_consumed", stall_req, 0);

        // 4: back-pressure fills the FIFO, credit must hold at depth
        dout_ready = 1'b0;
        credit_chk = 1'b1;
        start_frame(32'h0041_0000, 32'd128);
        cycle(40);
        chk("credit_full", acc_cnt, 16);
        chk("no_beats_while_blocked", exp_q.size(), 129);
        dout_ready = 1'b1;
        wait_done(1000);
        credit_chk = 1'b0;

        // 5: start while busy, and zero-count start, both ignored
        start_frame(32'h0042_0000, 32'd16);
        cycle(3);
        sig_address   = 32'h0043_0000;
        sig_pixel_cnt = 32'd4;
        sig_start     = 1'b1;
        cycle(1);
        sig_start = 1'b0;
        wait_done(300);
        sig_pixel_cnt = 32'd0;
        sig_start     = 1'b1;
        cycle(1);
        sig_start = 1'b0;
        chk("zero_cnt_busy", sig_busy, 0);
        chk("zero_cnt_read", avm_read, 0);
        cycle(10);
        chk("zero_cnt_no_done", done_seen, exp_frames);
        chk("zero_cnt_frame_cnt", sig_frame_cnt, exp_frames);

        // 6: reset mid-frame, then a clean frame
        start_frame(32'h0044_0000, 32'd64);
        cycle(10);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        exp_frames = 0;
        cycle(2);
        rst_n = 1'b1;
        cycle(1);
        start_frame(32'h0045_0000, 32'd4);
        wait_done(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
